// File: rtl/mvm4_in_seq.sv
// mvm4_in_seq: buffers one matrix-vector problem from a valid/ready producer
// and replays it to the mvm core as a start pulse followed by a gapless stream.
module mvm4_in_seq #(
    parameter int MAT_SCALE   = 4,
    parameter int INPUT_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic signed [INPUT_WIDTH-1:0] s_data,
    output logic                          start,
    output logic signed [INPUT_WIDTH-1:0] data_in,
    input  logic                          mvm_done,
    output logic                          busy,
    output logic [15:0]                   issue_cnt
);
    localparam int N  = MAT_SCALE * MAT_SCALE + MAT_SCALE;
    localparam int AW = $clog2(N);
    localparam int DW = (MAT_SCALE > 1) ? $clog2(MAT_SCALE) : 1;
    localparam logic [AW-1:0] LAST_W = AW'(N - 1);
    localparam logic [DW-1:0] LAST_D = DW'(MAT_SCALE - 1);

    typedef enum logic [2:0] {
        FILL,
        START,
        STREAM,
        WAIT_DONE,
        DRAIN
    } state_t;

    logic signed [INPUT_WIDTH-1:0] mem [N];

    state_t                        state_q, state_d;
    logic [AW-1:0]                 wcnt_q, wcnt_d;
    logic [AW-1:0]                 rcnt_q, rcnt_d;
    logic [DW-1:0]                 dcnt_q, dcnt_d;
    logic                          s_ready_q, s_ready_d;
    logic                          start_q, start_d;
    logic signed [INPUT_WIDTH-1:0] data_in_q, data_in_d;
    logic                          busy_q, busy_d;
    logic [15:0]                   issue_cnt_q, issue_cnt_d;
    logic                          wr_en;
    logic [AW-1:0]                 rd_nxt;

    assign rd_nxt = rcnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        rcnt_d      = rcnt_q;
        dcnt_d      = dcnt_q;
        s_ready_d   = s_ready_q;
        start_d     = 1'b0;
        data_in_d   = '0;
        busy_d      = busy_q;
        issue_cnt_d = issue_cnt_q;
        wr_en       = 1'b0;
        unique case (state_q)
            FILL: begin
                if (s_valid && s_ready_q) begin
                    wr_en = 1'b1;
                    if (wcnt_q == LAST_W) begin
                        wcnt_d    = '0;
                        state_d   = START;
                        start_d   = 1'b1;
                        s_ready_d = 1'b0;
                        busy_d    = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            START: begin
                state_d     = STREAM;
                issue_cnt_d = issue_cnt_q + 16'd1;
                rcnt_d      = '0;
                data_in_d   = mem[0];
            end
            STREAM: begin
                // rcnt_q indexes the word on data_in this cycle
                if (rcnt_q == LAST_W) begin
                    rcnt_d  = '0;
                    state_d = WAIT_DONE;
                end else begin
                    rcnt_d    = rd_nxt;
                    data_in_d = mem[rd_nxt];
                end
            end
            WAIT_DONE: begin
                if (mvm_done) begin
                    state_d = DRAIN;
                    dcnt_d  = '0;
                end
            end
            DRAIN: begin
                if (dcnt_q == LAST_D) begin
                    dcnt_d    = '0;
                    state_d   = FILL;
                    s_ready_d = 1'b1;
                    busy_d    = 1'b0;
                end else begin
                    dcnt_d = dcnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = FILL;
                s_ready_d = 1'b1;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FILL;
            wcnt_q      <= '0;
            rcnt_q      <= '0;
            dcnt_q      <= '0;
            s_ready_q   <= 1'b1;
            start_q     <= 1'b0;
            data_in_q   <= '0;
            busy_q      <= 1'b0;
            issue_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            rcnt_q      <= rcnt_d;
            dcnt_q      <= dcnt_d;
            s_ready_q   <= s_ready_d;
            start_q     <= start_d;
            data_in_q   <= data_in_d;
            busy_q      <= busy_d;
            issue_cnt_q <= issue_cnt_d;
        end
    end

    // Problem buffer is never cleared; stale words are simply overwritten.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem[wcnt_q] <= s_data;
        end
    end

    assign s_ready   = s_ready_q;
    assign start     = start_q;
    assign data_in   = data_in_q;
    assign busy      = busy_q;
    assign issue_cnt = issue_cnt_q;

endmodule

// File: tb/tb_mvm4_in_seq.sv
// tb_mvm4_in_seq: scenario tasks drive problems into the sequencer and compare
// the replayed stream and the resulting products against a reference model.
module tb_mvm4_in_seq;
    localparam int M = 4;
    localparam int N = M * M + M;

    typedef logic signed [7:0] word_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        mvm_done = 1'b0;
    word_t       s_data = '0;
    logic        s_ready;
    logic        start;
    logic        busy;
    word_t       data_in;
    logic [15:0] issue_cnt;

    int checks = 0;
    int errors = 0;
    int n_issued = 0;

    always #5 clk = ~clk;

    mvm4_in_seq #(
        .MAT_SCALE  (M),
        .INPUT_WIDTH(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .start    (start),
        .data_in  (data_in),
        .mvm_done (mvm_done),
        .busy     (busy),
        .issue_cnt(issue_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // y[r] = sum_c A[r][c] * x[c] over a row-major problem vector
    function automatic int yrow(input word_t v[$], input int r);
        int s = 0;
        for (int c = 0; c < M; c++)
            s += int'(v[r * M + c]) * int'(v[M * M + c]);
        return s;
    endfunction

    task automatic load(input word_t w[$], input bit gaps,
                        output int g, output bit to);
        int  i = 0;
        bit  ph = 1'b1;
        bit  acc;
        g  = 0;
        to = 1'b0;
        while (i < w.size()) begin
            if (g > 500) begin
                to = 1'b1;
                break;
            end
            s_valid = gaps ? ph : 1'b1;
            ph      = ~ph;
            s_data  = w[i];
            acc     = s_valid && s_ready;
            tick();
            g++;
            if (acc) i++;
        end
        s_valid = 1'b0;
    endtask

    task automatic stream(input int spur_at, input int rst_at,
                          output word_t q[$], output int st_hi,
                          output int rdy_hi);
        q      = {};
        st_hi  = 0;
        rdy_hi = 0;
        for (int i = 0; i < N; i++) begin
            tick();
            q.push_back(data_in);
            if (start) st_hi++;
            if (s_ready) rdy_hi++;
            mvm_done = (i == spur_at);
            if (i == rst_at) begin
                mvm_done = 1'b0;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                return;
            end
        end
        mvm_done = 1'b0;
    endtask

    task automatic finish_prob(input int lat, output int rdy_seen,
                               output int busy_lo, output int dnz);
        rdy_seen = 0;
        busy_lo  = 0;
        dnz      = 0;
        for (int k = 0; k < lat; k++) begin
            tick();
            if (s_ready) rdy_seen++;
            if (!busy) busy_lo++;
            if (data_in != 0) dnz++;
        end
        mvm_done = 1'b1;
        tick();
        mvm_done = 1'b0;
        for (int k = 0; k < M; k++) begin
            if (s_ready) rdy_seen++;
            if (!busy) busy_lo++;
            tick();
        end
    endtask

    function automatic void seq_problem(output word_t w[$]);
        w = {};
        for (int i = 1; i <= M * M; i++) w.push_back(word_t'(i));
        for (int i = 1; i <= M; i++) w.push_back(word_t'(i));
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (s_ready !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctl got rdy=%b st=%b busy=%b want 1 0 0",
                     s_ready, start, busy);
        end
        checks++;
        if (data_in !== 8'sd0 || issue_cnt !== 16'd0) begin
            errors++;
            $display("FAIL reset_data got d=%0d ic=%0d want 0 0",
                     data_in, issue_cnt);
        end
    endtask

    task automatic test_single(input bit gaps);
        word_t w[$];
        word_t q[$];
        int    g, st_hi, rdy_hi, rs, bl, dz, bad;
        int    yexp[M];
        bit    to;
        yexp = '{30, 70, 110, 150};
        seq_problem(w);
        load(w, gaps, g, to);
        checks++;
        if (to || g != (gaps ? 2 * N - 1 : N)) begin
            errors++;
            $display("FAIL load_cycles got %0d want %0d",
                     g, gaps ? 2 * N - 1 : N);
        end
        checks++;
        if (start !== 1'b1 || busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL start_cycle got st=%b busy=%b rdy=%b want 1 1 0",
                     start, busy, s_ready);
        end
        n_issued++;
        stream(-1, -1, q, st_hi, rdy_hi);
        bad = 0;
        for (int i = 0; i < N; i++) if (q[i] !== w[i]) bad++;
        checks++;
        if (bad != 0 || st_hi != 0 || rdy_hi != 0) begin
            errors++;
            $display("FAIL stream got bad=%0d st=%0d rdy=%0d want 0 0 0",
                     bad, st_hi, rdy_hi);
        end
        for (int r = 0; r < M; r++) begin
            checks++;
            if (yrow(q, r) != yexp[r]) begin
                errors++;
                $display("FAIL y%0d got %0d want %0d", r, yrow(q, r), yexp[r]);
            end
        end
        checks++;
        if (issue_cnt !== 16'(n_issued)) begin
            errors++;
            $display("FAIL issue_cnt got %0d want %0d", issue_cnt, n_issued);
        end
        finish_prob(5, rs, bl, dz);
        checks++;
        if (rs != 0 || bl != 0 || dz != 0 || s_ready !== 1'b1 || busy !== 1'b0)
        begin
            errors++;
            $display("FAIL drain got rdy=%0d blo=%0d dnz=%0d end=%b%b want 0 0 0 10",
                     rs, bl, dz, s_ready, busy);
        end
    endtask

    task automatic test_holdoff();
        word_t w[$];
        word_t w2[$];
        word_t q[$];
        int    g, st_hi, rdy_hi, rs, bl, dz;
        bit    to;
        seq_problem(w);
        w2 = {};
        for (int i = 0; i < M * M; i++) w2.push_back(-8'sd5);
        for (int i = 0; i < M; i++) w2.push_back(8'sd3);
        load(w, 1'b0, g, to);
        n_issued++;
        s_valid = 1'b1;
        s_data  = w2[0];
        stream(-1, -1, q, st_hi, rdy_hi);
        finish_prob(6, rs, bl, dz);
        checks++;
        if (rdy_hi != 0 || rs != 0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL holdoff got rdy_str=%0d rdy_wd=%0d end=%b want 0 0 1",
                     rdy_hi, rs, s_ready);
        end
        load(w2, 1'b0, g, to);
        checks++;
        if (to || g != N || start !== 1'b1) begin
            errors++;
            $display("FAIL holdoff_load got %0d st=%b want %0d 1", g, start, N);
        end
        n_issued++;
        stream(-1, -1, q, st_hi, rdy_hi);
        for (int r = 0; r < M; r++) begin
            checks++;
            if (yrow(q, r) != -60) begin
                errors++;
                $display("FAIL holdoff_y%0d got %0d want -60", r, yrow(q, r));
            end
        end
        checks++;
        if (issue_cnt !== 16'(n_issued)) begin
            errors++;
            $display("FAIL holdoff_ic got %0d want %0d", issue_cnt, n_issued);
        end
        finish_prob(3, rs, bl, dz);
    endtask

    task automatic test_spurious();
        word_t w[$];
        word_t q[$];
        int    g, st_hi, rdy_hi, rs, bl, dz, bad;
        bit    to;
        seq_problem(w);
        load(w, 1'b0, g, to);
        n_issued++;
        stream(9, -1, q, st_hi, rdy_hi);
        bad = 0;
        for (int i = 0; i < N; i++) if (q[i] !== w[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL spur_stream got bad=%0d want 0", bad);
        end
        finish_prob(8, rs, bl, dz);
        checks++;
        if (rs != 0 || bl != 0 || s_ready !== 1'b1) begin
            errors++;
            $display("FAIL spur_wait got rdy=%0d blo=%0d end=%b want 0 0 1",
                     rs, bl, s_ready);
        end
    endtask

    task automatic test_reset_stream();
        word_t w[$];
        word_t q[$];
        int    g, st_hi, rdy_hi, rs, bl, dz, bad;
        bit    to;
        seq_problem(w);
        load(w, 1'b0, g, to);
        stream(-1, 7, q, st_hi, rdy_hi);
        n_issued = 0;
        checks++;
        if (q.size() != 8 || q[7] !== w[7]) begin
            errors++;
            $display("FAIL rst_word7 got n=%0d want 8", q.size());
        end
        checks++;
        if (start !== 1'b0 || data_in !== 8'sd0 || s_ready !== 1'b1 ||
            busy !== 1'b0 || issue_cnt !== 16'd0) begin
            errors++;
            $display("FAIL rst_stream got st=%b d=%0d rdy=%b busy=%b ic=%0d want 0 0 1 0 0",
                     start, data_in, s_ready, busy, issue_cnt);
        end
        w = {};
        for (int i = 0; i < N; i++) w.push_back(word_t'($urandom));
        load(w, 1'b0, g, to);
        checks++;
        if (to || g != N || start !== 1'b1) begin
            errors++;
            $display("FAIL rst_reload got %0d st=%b want %0d 1", g, start, N);
        end
        n_issued++;
        stream(-1, -1, q, st_hi, rdy_hi);
        bad = 0;
        for (int r = 0; r < M; r++) if (yrow(q, r) != yrow(w, r)) bad++;
        checks++;
        if (bad != 0 || issue_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_fresh got bad_y=%0d ic=%0d want 0 1",
                     bad, issue_cnt);
        end
        finish_prob(2, rs, bl, dz);
    endtask

    task automatic test_extremes();
        word_t w[$];
        word_t q[$];
        int    g, st_hi, rdy_hi, rs, bl, dz, bad;
        bit    to;
        w = {};
        for (int i = 0; i < N; i++) w.push_back(i[0] ? 8'sd127 : -8'sd128);
        load(w, 1'b1, g, to);
        n_issued++;
        stream(-1, -1, q, st_hi, rdy_hi);
        bad = 0;
        for (int i = 0; i < N; i++)
            if (q[i] !== (i[0] ? 8'h7F : 8'h80)) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL extremes got bad=%0d first=%h want 0 80", bad, q[0]);
        end
        for (int r = 0; r < M; r++) begin
            checks++;
            if (yrow(q, r) != yrow(w, r)) begin
                errors++;
                $display("FAIL ext_y%0d got %0d want %0d",
                         r, yrow(q, r), yrow(w, r));
            end
        end
        finish_prob(1, rs, bl, dz);
    endtask

    task automatic test_random();
        word_t w[$];
        word_t p[$];
        word_t q[$];
        int    g, st_hi, rdy_hi, rs, bl, dz, bad, k;
        int    rst_iter;
        bit    to;
        rst_iter = $urandom_range(900, 100);
        for (int it = 0; it < 1000; it++) begin
            w = {};
            for (int i = 0; i < N; i++) w.push_back(word_t'($urandom));
            if (it == rst_iter) begin
                k = $urandom_range(N - 1, 1);
                p = {};
                for (int i = 0; i < k; i++) p.push_back(word_t'($urandom));
                load(p, 1'b0, g, to);
                reset = 1'b1;
                tick();
                reset = 1'b0;
                n_issued = 0;
                checks++;
                if (issue_cnt !== 16'd0 || s_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL rand_rst got ic=%0d rdy=%b want 0 1",
                             issue_cnt, s_ready);
                end
            end
            load(w, ($urandom_range(3, 0) == 0), g, to);
            checks++;
            if (to || start !== 1'b1) begin
                errors++;
                $display("FAIL rand_load it=%0d got st=%b to=%b want 1 0",
                         it, start, to);
            end
            n_issued++;
            stream(-1, -1, q, st_hi, rdy_hi);
            bad = 0;
            for (int i = 0; i < N; i++) if (q[i] !== w[i]) bad++;
            for (int r = 0; r < M; r++) if (yrow(q, r) != yrow(w, r)) bad++;
            if (issue_cnt !== 16'(n_issued)) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL rand it=%0d got bad=%0d ic=%0d want 0 %0d",
                         it, bad, issue_cnt, n_issued);
            end
            finish_prob($urandom_range(4, 1), rs, bl, dz);
        end
    endtask

    initial begin
        test_reset();
        test_single(1'b0);
        test_single(1'b1);
        test_holdoff();
        test_spurious();
        test_reset_stream();
        test_extremes();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
